// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_pkg;

   localparam int REG_W = 5;

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_MULDIV = 1'b1
   } state_e;

   // Per-stage register control: enable and bubble insert.
   typedef struct packed {
      logic ce;
      logic flush;
   } stage_ctl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage-control outputs of the pipeline sequencer.
interface pipe_ctrl_if #(parameter int CW = 16);
   import pipe_pkg::*;

   logic [REG_W-1:0] id_rs_i;
   logic [REG_W-1:0] id_rt_i;
   logic             id_uses_rs_i;
   logic             id_uses_rt_i;
   logic             ex_memread_i;
   logic [REG_W-1:0] ex_rd_i;
   logic             ex_branch_taken_i;
   logic             ex_muldiv_start_i;
   logic             imem_ready_i;
   logic             dmem_req_i;
   logic             dmem_ready_i;
   logic             stall_clr_i;

   logic             pc_ce_o;
   logic             ifid_ce_o;
   logic             idex_ce_o;
   logic             exmem_ce_o;
   logic             memwb_ce_o;
   logic             ifid_flush_o;
   logic             idex_flush_o;
   logic             exmem_flush_o;
   logic             memwb_flush_o;
   logic             muldiv_busy_o;
   logic             muldiv_done_o;
   logic [CW-1:0]    stall_cnt_o;

   // Sequencer side.
   modport slave (
      input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
             ex_branch_taken_i, ex_muldiv_start_i, imem_ready_i, dmem_req_i,
             dmem_ready_i, stall_clr_i,
      output pc_ce_o, ifid_ce_o, idex_ce_o, exmem_ce_o, memwb_ce_o,
             ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
             muldiv_busy_o, muldiv_done_o, stall_cnt_o
   );

   // Pipeline datapath side.
   modport master (
      output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, ex_memread_i, ex_rd_i,
             ex_branch_taken_i, ex_muldiv_start_i, imem_ready_i, dmem_req_i,
             dmem_ready_i, stall_clr_i,
      input  pc_ce_o, ifid_ce_o, idex_ce_o, exmem_ce_o, memwb_ce_o,
             ifid_flush_o, idex_flush_o, exmem_flush_o, memwb_flush_o,
             muldiv_busy_o, muldiv_done_o, stall_cnt_o
   );

endinterface

// File: rtl/pipe_ctrl_dffe.sv
// Clock-enabled D flip-flop cell with asynchronous active-low reset.
module pipe_ctrl_dffe #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Capture d when enabled, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= RST_VAL;
      else if (en) q <= d;
   end

endmodule

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard decode: ID reads a register the EX load has not produced yet.
module hazard_detect
   import pipe_pkg::*;
(
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_uses_rs_i,
   input  logic             id_uses_rt_i,
   output logic             lu_o
);

   // $zero is never a real dependency.
   always_comb begin
      lu_o = ex_memread_i && (ex_rd_i != '0) &&
             ((id_uses_rs_i && (id_rs_i == ex_rd_i)) ||
              (id_uses_rt_i && (id_rt_i == ex_rd_i)));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority-resolves dmem wait,
// mul/div occupancy, taken branch, load-use and fetch wait into register
// enables and bubbles, and counts cycles in which the PC is frozen.
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MULDIV_LAT = 4,
   parameter int CW         = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   pipe_ctrl_if.slave  bus
);

   localparam int CNT_W = ($clog2(MULDIV_LAT) < 2) ? 2 : $clog2(MULDIV_LAT);

   logic             run_q;
   logic [0:0]       st_raw_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    scnt_q, scnt_d;
   logic             scnt_en;

   logic             lu, dstall, istall, mstall, release_w;
   logic             pc_ce;
   stage_ctl_t       ifid_c, idex_c, exmem_c, memwb_c;

   hazard_detect u_hazard (
      .ex_memread_i (bus.ex_memread_i),
      .ex_rd_i      (bus.ex_rd_i),
      .id_rs_i      (bus.id_rs_i),
      .id_rt_i      (bus.id_rt_i),
      .id_uses_rs_i (bus.id_uses_rs_i),
      .id_uses_rt_i (bus.id_uses_rt_i),
      .lu_o         (lu)
   );

   assign dstall  = bus.dmem_req_i & ~bus.dmem_ready_i;
   assign istall  = ~bus.imem_ready_i;
   assign state_q = state_e'(st_raw_q);

   // run_q holds all controls low for the first clock after reset release.
   pipe_ctrl_dffe #(.W(1)) u_run (
      .clk (clk), .rst_n (rst_n), .en (1'b1), .d (1'b1), .q (run_q)
   );

   pipe_ctrl_dffe #(.W(1), .RST_VAL(ST_RUN)) u_state (
      .clk (clk), .rst_n (rst_n), .en (1'b1), .d (state_d), .q (st_raw_q)
   );

   pipe_ctrl_dffe #(.W(CNT_W)) u_cnt (
      .clk (clk), .rst_n (rst_n), .en (1'b1), .d (cnt_d), .q (cnt_q)
   );

   pipe_ctrl_dffe #(.W(CW)) u_scnt (
      .clk (clk), .rst_n (rst_n), .en (scnt_en), .d (scnt_d), .q (scnt_q)
   );

   // Mul/div occupancy FSM: the start cycle plus MULDIV_LAT-1 counted cycles;
   // release waits for any dmem stall so EX and MEM advance together.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      release_w = (state_q == ST_MULDIV) && (cnt_q == '0) && !dstall;
      mstall    = ((state_q == ST_RUN) && bus.ex_muldiv_start_i) ||
                  ((state_q == ST_MULDIV) && !release_w);
      case (state_q)
         ST_RUN: begin
            if (run_q && bus.ex_muldiv_start_i && !dstall) begin
               state_d = ST_MULDIV;
               cnt_d   = CNT_W'(MULDIV_LAT - 2);
            end
         end
         ST_MULDIV: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            if (release_w)   state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Stage enables/bubbles, first matching hazard wins.
   always_comb begin
      pc_ce   = 1'b1;
      ifid_c  = '{ce: 1'b1, flush: 1'b0};
      idex_c  = '{ce: 1'b1, flush: 1'b0};
      exmem_c = '{ce: 1'b1, flush: 1'b0};
      memwb_c = '{ce: 1'b1, flush: 1'b0};
      if (dstall) begin
         pc_ce = 1'b0; ifid_c.ce = 1'b0; idex_c.ce = 1'b0; exmem_c.ce = 1'b0;
         memwb_c.flush = 1'b1;
      end else if (mstall) begin
         pc_ce = 1'b0; ifid_c.ce = 1'b0; idex_c.ce = 1'b0;
         exmem_c.flush = 1'b1;
      end else if (bus.ex_branch_taken_i) begin
         ifid_c.flush = 1'b1; idex_c.flush = 1'b1;
      end else if (lu) begin
         pc_ce = 1'b0; ifid_c.ce = 1'b0;
         idex_c.flush = 1'b1;
      end else if (istall) begin
         pc_ce = 1'b0;
         ifid_c.flush = 1'b1;
      end
      if (!run_q) begin
         pc_ce   = 1'b0;
         ifid_c  = '0;
         idex_c  = '0;
         exmem_c = '0;
         memwb_c = '0;
      end
   end

   // Saturating count of frozen-PC cycles; clear wins.
   always_comb begin
      scnt_en = bus.stall_clr_i || (run_q && !pc_ce);
      scnt_d  = (scnt_q == '1) ? scnt_q : scnt_q + CW'(1);
      if (bus.stall_clr_i) scnt_d = '0;
   end

   assign bus.pc_ce_o       = pc_ce;
   assign bus.ifid_ce_o     = ifid_c.ce;
   assign bus.idex_ce_o     = idex_c.ce;
   assign bus.exmem_ce_o    = exmem_c.ce;
   assign bus.memwb_ce_o    = memwb_c.ce;
   assign bus.ifid_flush_o  = ifid_c.flush;
   assign bus.idex_flush_o  = idex_c.flush;
   assign bus.exmem_flush_o = exmem_c.flush;
   assign bus.memwb_flush_o = memwb_c.flush;
   assign bus.muldiv_busy_o = run_q & mstall;
   assign bus.muldiv_done_o = run_q & release_w;
   assign bus.stall_cnt_o   = scnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each step pushes the expected controls and
// stall count; the negedge monitor pops and compares.
module tb_pipe_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_if #(.CW(4)) bus ();

   pipe_ctrl #(.MULDIV_LAT(4), .CW(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // {pc,ifid,idex,exmem,memwb ce | ifid,idex,exmem,memwb flush | busy, done}
   localparam logic [10:0] ZERO = 11'b00000_0000_00;
   localparam logic [10:0] NORM = 11'b11111_0000_00;
   localparam logic [10:0] LU   = 11'b00111_0100_00;
   localparam logic [10:0] IST  = 11'b01111_1000_00;
   localparam logic [10:0] BR   = 11'b11111_1100_00;
   localparam logic [10:0] DST  = 11'b00001_0001_00;
   localparam logic [10:0] DSTB = 11'b00001_0001_10;
   localparam logic [10:0] MUL  = 11'b00011_0010_10;
   localparam logic [10:0] DONE = 11'b11111_0000_01;

   typedef struct {
      string       tag;
      logic [10:0] ctl;
      logic [3:0]  cnt;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk = 0;
   int         n_pass = 0;
   logic [3:0] mcnt = '0;
   logic       mrun = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   // Push expectation for the current input set, then advance one clock.
   task automatic step(input string tag, input logic [10:0] ctl);
      exp_t e;
      logic clr;
      if (!rst_n) begin mcnt = '0; mrun = 1'b0; end
      e.tag = tag; e.ctl = ctl; e.cnt = mcnt;
      exp_q.push_back(e);
      clr = bus.stall_clr_i;
      @(posedge clk); #1;
      if (!rst_n) begin
         mcnt = '0; mrun = 1'b0;
      end else begin
         if (clr)                                  mcnt = '0;
         else if (mrun && !ctl[10] && mcnt != 4'hf) mcnt = mcnt + 4'd1;
         mrun = 1'b1;
      end
   endtask

   task automatic idle();
      bus.id_rs_i = 5'd1; bus.id_rt_i = 5'd2;
      bus.id_uses_rs_i = 1'b0; bus.id_uses_rt_i = 1'b0;
      bus.ex_memread_i = 1'b0; bus.ex_rd_i = 5'd0;
      bus.ex_branch_taken_i = 1'b0; bus.ex_muldiv_start_i = 1'b0;
      bus.imem_ready_i = 1'b1; bus.dmem_req_i = 1'b0; bus.dmem_ready_i = 1'b1;
      bus.stall_clr_i = 1'b0;
   endtask

   task automatic clear_cnt();
      bus.stall_clr_i = 1'b1;
      step("clr", NORM);
      bus.stall_clr_i = 1'b0;
   endtask

   // Compare DUT against the oldest expectation, away from the active edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, "_ctl"},
             {21'd0, bus.pc_ce_o, bus.ifid_ce_o, bus.idex_ce_o, bus.exmem_ce_o,
              bus.memwb_ce_o, bus.ifid_flush_o, bus.idex_flush_o, bus.exmem_flush_o,
              bus.memwb_flush_o, bus.muldiv_busy_o, bus.muldiv_done_o},
             {21'd0, e.ctl});
         chk({e.tag, "_cnt"}, {28'd0, bus.stall_cnt_o}, {28'd0, e.cnt});
      end
   end

   initial begin
      idle();
      @(posedge clk); #1;
      step("rst", ZERO);
      rst_n = 1'b1;
      step("first", ZERO);
      step("run", NORM);

      // Load-use on rs, then $zero destination, then rt / unused-rs cases.
      clear_cnt();
      bus.ex_memread_i = 1'b1; bus.ex_rd_i = 5'd8;
      bus.id_uses_rs_i = 1'b1; bus.id_rs_i = 5'd8;
      step("lu_rs", LU);
      idle();
      step("lu_after", NORM);
      bus.ex_memread_i = 1'b1; bus.ex_rd_i = 5'd0;
      bus.id_uses_rs_i = 1'b1; bus.id_rs_i = 5'd0;
      step("lu_r0", NORM);
      idle();
      bus.ex_memread_i = 1'b1; bus.ex_rd_i = 5'd9;
      bus.id_uses_rt_i = 1'b1; bus.id_rt_i = 5'd9;
      step("lu_rt", LU);
      bus.id_uses_rt_i = 1'b0; bus.id_rs_i = 5'd9;
      step("lu_unused", NORM);
      idle();

      // Mul/div with start held: 3 busy cycles then a done cycle.
      clear_cnt();
      bus.ex_muldiv_start_i = 1'b1;
      for (int i = 0; i < 3; i++) step("md_busy", MUL);
      step("md_done", DONE);
      idle();
      step("md_after", NORM);

      // Dmem wait for 5 cycles, then normal flow.
      clear_cnt();
      bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) step("dwait", DST);
      bus.dmem_ready_i = 1'b1;
      step("dwait_end", NORM);
      idle();

      // Branch beats load-use and fetch stall; fetch stall alone.
      clear_cnt();
      bus.ex_branch_taken_i = 1'b1;
      bus.ex_memread_i = 1'b1; bus.ex_rd_i = 5'd8;
      bus.id_uses_rs_i = 1'b1; bus.id_rs_i = 5'd8;
      step("br_lu", BR);
      bus.imem_ready_i = 1'b0;
      step("br_ist", BR);
      idle();
      bus.imem_ready_i = 1'b0;
      step("ist", IST);
      idle();
      step("br_after", NORM);

      // Mul/div overlapped by a 6-cycle dmem stall from its 2nd cycle.
      clear_cnt();
      bus.ex_muldiv_start_i = 1'b1;
      step("mdd_start", MUL);
      bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
      for (int i = 0; i < 6; i++) step("mdd_dst", DSTB);
      bus.dmem_ready_i = 1'b1;
      step("mdd_done", DONE);
      idle();
      step("mdd_after", NORM);

      // Reset in the middle of a mul/div.
      bus.ex_muldiv_start_i = 1'b1;
      step("mdr_busy0", MUL);
      step("mdr_busy1", MUL);
      rst_n = 1'b0;
      step("mdr_rst", ZERO);
      rst_n = 1'b1;
      bus.ex_muldiv_start_i = 1'b0;
      step("mdr_first", ZERO);
      step("mdr_run", NORM);

      // Counter saturation at 15, then clear.
      bus.imem_ready_i = 1'b0;
      for (int i = 0; i < 20; i++) step("sat", IST);
      bus.stall_clr_i = 1'b1;
      step("sat_clr", IST);
      idle();
      step("sat_zero", NORM);

      @(negedge clk);
      chk("drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
